// File: rtl/mem_bus_arbiter.sv
// Round-robin owner arbitration for the shared main-memory port, with a one-cycle
// turnaround between owners and optional hold-time preemption.
module mem_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 64,
    parameter int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic [N_REQ-1:0] i_Request,
    output logic [N_REQ-1:0] o_Grant,
    output logic [IDX_W-1:0] o_Grant_Index,
    output logic             o_Bus_Busy,
    output logic             o_Preempt
);

    localparam int               CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(N_REQ);
    localparam bit               HOLD_EN  = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // (base + offs) mod N_REQ; both operands are below N_REQ, so one subtraction suffices.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      offs);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + (IDX_W + 1)'(offs);
        if (sum >= N_WIDE) sum = sum - N_WIDE;
        return sum[IDX_W-1:0];
    endfunction

    // Rotate so the pointer position sits at bit 0; scanning downwards lets the
    // lowest rotated position (highest priority) overwrite any later match.
    function automatic pick_t arbitrate(input logic [N_REQ-1:0] req,
                                        input logic [IDX_W-1:0] ptr);
        logic [2*N_REQ-1:0] rot;
        pick_t              pick;
        rot  = {req, req} >> ptr;
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick.found = 1'b1;
                pick.idx   = wrap_add(ptr, unsigned'(i));
            end
        end
        return pick;
    endfunction

    function automatic logic [N_REQ-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] dec;
        for (int i = 0; i < N_REQ; i++) dec[i] = (idx == IDX_W'(i));
        return dec;
    endfunction

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preempt_q, preempt_d;

    pick_t pick;
    logic  owner_req;
    logic  others_req;

    assign pick       = arbitrate(i_Request, ptr_q);
    assign owner_req  = |(i_Request & grant_q);
    assign others_req = |(i_Request & ~grant_q);

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;

        case (state_q)
            S_GRANT: begin
                if (!owner_req || (HOLD_EN && (cnt_q == CNT_LAST) && others_req)) begin
                    state_d   = S_TURN;
                    grant_d   = '0;
                    ptr_d     = wrap_add(owner_q, 1);
                    preempt_d = owner_req;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // IDLE and TURNAROUND arbitrate identically; only the entry path differs.
                state_d = S_IDLE;
                grant_d = '0;
                if (pick.found) begin
                    state_d = S_GRANT;
                    owner_d = pick.idx;
                    grant_d = decode(pick.idx);
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign o_Grant       = grant_q;
    assign o_Grant_Index = owner_q;
    assign o_Bus_Busy    = (state_q == S_GRANT);
    assign o_Preempt     = preempt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized request traffic,
// all checked against an owner/pointer reference model.
module tb_mem_bus_arbiter;

    localparam int N_REQ    = 4;
    localparam int MAX_HOLD = 8;
    localparam int IDX_W    = 2;

    logic             clk = 1'b0;
    logic             i_Reset = 1'b1;
    logic [N_REQ-1:0] i_Request = '0;
    logic [N_REQ-1:0] o_Grant;
    logic [IDX_W-1:0] o_Grant_Index;
    logic             o_Bus_Busy;
    logic             o_Preempt;

    mem_bus_arbiter #(
        .N_REQ   (N_REQ),
        .MAX_HOLD(MAX_HOLD),
        .IDX_W   (IDX_W)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (i_Reset),
        .i_Request    (i_Request),
        .o_Grant      (o_Grant),
        .o_Grant_Index(o_Grant_Index),
        .o_Bus_Busy   (o_Bus_Busy),
        .o_Preempt    (o_Preempt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference model: current owner (-1 = none), grant edges held, round-robin
    // pointer, last owner index, and the preempt pulse.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_idx   = 0;
    bit m_pre   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input logic [N_REQ-1:0] r, input logic rst);
        logic [N_REQ-1:0] own_mask;
        m_pre = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_idx   = 0;
        end else if (m_owner >= 0) begin
            m_held++;
            own_mask = 4'b0001 << m_owner;
            if ((r & own_mask) == 0) begin
                m_ptr   = (m_owner + 1) % N_REQ;
                m_owner = -1;
            end else if (MAX_HOLD != 0 && m_held == MAX_HOLD && (r & ~own_mask) != 0) begin
                m_ptr   = (m_owner + 1) % N_REQ;
                m_owner = -1;
                m_pre   = 1'b1;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                int c;
                c = (m_ptr + k) % N_REQ;
                if (((r >> c) & 4'b0001) != 0) begin
                    m_owner = c;
                    m_idx   = c;
                    m_held  = 0;
                    break;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [N_REQ-1:0] exp_grant;
        exp_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check("grant",   32'(o_Grant),       32'(exp_grant));
        check("index",   32'(o_Grant_Index), 32'(m_idx));
        check("busy",    32'(o_Bus_Busy),    32'(m_owner >= 0));
        check("preempt", 32'(o_Preempt),     32'(m_pre));
    endtask

    // One clock: drive on the falling edge, predict, then sample 1 after the rising edge.
    task automatic step(input logic [N_REQ-1:0] req, input logic rst);
        @(negedge clk);
        i_Request = req;
        i_Reset   = rst;
        model_edge(req, rst);
        @(posedge clk);
        #1;
        cyc++;
        compare_model();
    endtask

    initial begin
        int n;
        int pre_seen;
        logic [N_REQ-1:0] req;
        logic [N_REQ-1:0] seq[$];
        logic [N_REQ-1:0] rr_exp [5];

        // Reset held with all requests pending, then first grant.
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        check("rst_grant", 32'(o_Grant), 32'h0);
        step(4'b1111, 1'b0);
        check("first_grant", 32'(o_Grant), 32'h1);
        check("first_index", 32'(o_Grant_Index), 32'h0);

        // Single request, dropped at the fifth edge after the grant.
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        check("single_grant", 32'(o_Grant), 32'h4);
        check("single_index", 32'(o_Grant_Index), 32'h2);
        for (int i = 0; i < 4; i++) step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        check("single_release", 32'(o_Grant), 32'h0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // Round robin: each owner drops its bit for one edge after three grant cycles.
        step(4'b0000, 1'b1);
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 18; i++) begin
            req = 4'b1111;
            if (m_owner >= 0 && m_held == 2) req = req & ~(4'b0001 << m_owner);
            step(req, 1'b0);
            if (o_Grant != 0 && (seq.size() == 0 || seq[$] != o_Grant)) seq.push_back(o_Grant);
        end
        check("rr_len_ok", 32'(seq.size() >= 5), 32'h1);
        if (seq.size() >= 5)
            for (int i = 0; i < 5; i++) check("rr_seq", 32'(seq[i]), 32'(rr_exp[i]));

        // Preemption: requester 0 holds, requester 1 joins two cycles in.
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        n = 0;
        pre_seen = 0;
        for (int i = 0; i < 20 && pre_seen == 0; i++) begin
            step((n >= 1) ? 4'b0011 : 4'b0001, 1'b0);
            n++;
            if (o_Preempt) pre_seen = 1;
        end
        check("preempt_seen", 32'(pre_seen), 32'h1);
        check("preempt_edge", 32'(n), 32'd8);
        check("preempt_gap", 32'(o_Grant), 32'h0);
        step(4'b0011, 1'b0);
        check("preempt_next", 32'(o_Grant), 32'h2);
        for (int i = 0; i < 3; i++) step(4'b0011, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        check("preempt_return", 32'(o_Grant), 32'h1);

        // No contention: a lone owner is never preempted.
        step(4'b0000, 1'b1);
        pre_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(4'b1000, 1'b0);
            if (o_Preempt) pre_seen++;
        end
        check("lone_grant", 32'(o_Grant), 32'h8);
        check("lone_no_preempt", 32'(pre_seen), 32'h0);

        // Reset while requester 1 owns the bus.
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b0);
        check("mid_owner", 32'(o_Grant), 32'h2);
        step(4'b1111, 1'b1);
        check("mid_rst_grant", 32'(o_Grant), 32'h0);
        check("mid_rst_busy", 32'(o_Bus_Busy), 32'h0);
        step(4'b1111, 1'b0);
        check("mid_after", 32'(o_Grant), 32'h1);

        // Randomized sticky requests with occasional reset.
        req = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < N_REQ; b++)
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            step(req, ($urandom_range(0, 199) == 0));
            check("onehot", 32'($countones(o_Grant) <= 1), 32'h1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
